// File: rtl/pc_unit_if.sv
// Fetch / decode bundle for pc_unit: imem request/response, decode handshake,
// branch resolution inputs and status outputs.
interface pc_unit_if;
  logic        pc_src;
  logic [31:0] target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misalign_err;
  logic [31:0] err_pc;
  logic [63:0] instret;

  // pc_unit side
  modport master (
    input  pc_src, target, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    output imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
           misalign_err, err_pc, instret
  );

  // memory / decode environment side
  modport slave (
    output pc_src, target, imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready,
    input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
           misalign_err, err_pc, instret
  );
endinterface

// File: rtl/pc_unit.sv
// Program counter and single-entry fetch buffer. One imem request in flight at
// most; the fetched word is held until decode retires it, then the PC advances
// (PC+4 or branch target). A misaligned redirect halts the unit until reset.
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic       clk,
  input  logic       rst_n,
  pc_unit_if.master  bus
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  logic [1:0]  state_q,   state_d;
  logic [31:0] pc_q,      pc_d;
  logic [31:0] instr_q,   instr_d;
  logic [31:0] ipc_q,     ipc_d;
  logic        err_q,     err_d;
  logic [31:0] errpc_q,   errpc_d;
  logic [63:0] instret_q, instret_d;
  logic        retire;
  logic        bad_tgt;

  // Next-state: fetch handshake, response capture, retire/redirect decisions
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    ipc_d     = ipc_q;
    err_d     = err_q;
    errpc_d   = errpc_q;
    instret_d = instret_q;
    retire    = (state_q == S_HOLD) && bus.instr_ready;
    bad_tgt   = bus.pc_src && (bus.target[1:0] != 2'b00);
    case (state_q)
      S_REQ:  if (bus.imem_req_ready) state_d = S_WAIT;
      S_WAIT: if (bus.imem_rsp_valid) begin
        instr_d = bus.imem_rsp_data;
        ipc_d   = pc_q;
        state_d = S_HOLD;
      end
      S_HOLD: if (retire) begin
        if (bad_tgt) begin
          // PC and instret stay put so err_pc points at the faulting redirect
          err_d   = 1'b1;
          errpc_d = bus.target;
          state_d = S_HALT;
        end else begin
          pc_d      = bus.pc_src ? bus.target : pc_q + 32'd4;
          instret_d = instret_q + 64'd1;
          state_d   = S_REQ;
        end
      end
      default: state_d = S_HALT;
    endcase
  end

  // State registers; reset also abandons any fetch in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      ipc_q     <= '0;
      err_q     <= 1'b0;
      errpc_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      ipc_q     <= ipc_d;
      err_q     <= err_d;
      errpc_q   <= errpc_d;
      instret_q <= instret_d;
    end
  end

  // Request is masked while reset is held so nothing leaks out during reset
  assign bus.imem_req_valid = rst_n && (state_q == S_REQ);
  assign bus.imem_addr      = pc_q;
  assign bus.instr_valid    = (state_q == S_HOLD);
  assign bus.instr          = instr_q;
  assign bus.instr_pc       = ipc_q;
  assign bus.misalign_err   = err_q;
  assign bus.err_pc         = errpc_q;
  assign bus.instret        = instret_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed table, hand sequences for backpressure / reset /
// wrap, then randomized traffic against a transaction-level model.
module tb_pc_unit;
  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rst2_n = 1'b1;
  always #5 clk = ~clk;

  pc_unit_if bus();
  pc_unit_if bus2();

  pc_unit #(.RESET_PC(32'h0000_0000)) dut  (.clk(clk), .rst_n(rst_n),  .bus(bus));
  pc_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (.clk(clk), .rst_n(rst2_n), .bus(bus2));

  int n_vec = 0;
  int n_err = 0;
  int hs = 0;

  // handshake counter for the "exactly one request" check
  always @(posedge clk) if (rst_n && bus.imem_req_valid && bus.imem_req_ready) hs++;

  typedef struct {
    logic        rdy, rsp;
    logic [31:0] data;
    logic        ir, ps;
    logic [31:0] tg;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_instr, e_ipc;
    logic [63:0] e_ret;
    logic        e_err;
    logic [31:0] e_epc;
  } vec_t;

  vec_t tbl [14];

  function automatic vec_t mk(input logic rdy, input logic rsp, input logic [31:0] data,
                              input logic ir, input logic ps, input logic [31:0] tg,
                              input logic erv, input logic [31:0] eaddr, input logic eiv,
                              input logic [31:0] ei, input logic [31:0] eipc,
                              input logic [63:0] eret, input logic eerr, input logic [31:0] eepc);
    vec_t v;
    v.rdy = rdy; v.rsp = rsp; v.data = data; v.ir = ir; v.ps = ps; v.tg = tg;
    v.e_rv = erv; v.e_addr = eaddr; v.e_iv = eiv; v.e_instr = ei; v.e_ipc = eipc;
    v.e_ret = eret; v.e_err = eerr; v.e_epc = eepc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rsp, input logic [31:0] data,
                       input logic ir, input logic ps, input logic [31:0] tg);
    bus.imem_req_ready = rdy;
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = data;
    bus.instr_ready    = ir;
    bus.pc_src         = ps;
    bus.target         = tg;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " rst req_valid"}, bus.imem_req_valid, 0);
    chk({tag, " rst instr_valid"}, bus.instr_valid, 0);
    chk({tag, " rst addr"}, bus.imem_addr, 0);
    chk({tag, " rst instr"}, bus.instr, 0);
    chk({tag, " rst instr_pc"}, bus.instr_pc, 0);
    chk({tag, " rst misalign"}, bus.misalign_err, 0);
    chk({tag, " rst err_pc"}, bus.err_pc, 0);
    chk({tag, " rst instret"}, bus.instret, 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    drive(F, F, 32'h0, F, F, 32'h0);
    #1 check_reset(tag);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk({tag, " first req"}, bus.imem_req_valid, 1);
    chk({tag, " first addr"}, bus.imem_addr, 0);
  endtask

  // transaction-level model state for the random phase
  logic [31:0] m_pc, m_instr, m_errpc;
  logic [63:0] m_instret;
  logic        m_halt, m_err, m_pending, m_have;
  int          m_delay, halt_cnt;

  task automatic model_init();
    m_pc = 32'h0; m_instr = 32'h0; m_errpc = 32'h0; m_instret = 64'd0;
    m_halt = 1'b0; m_err = 1'b0; m_pending = 1'b0; m_have = 1'b0;
    m_delay = 0; halt_cnt = 0;
  endtask

  initial begin
    logic        rdy, rsp, ir, ps, exp_rv;
    logic [31:0] data, tg;
    int          hs_base, r;

    drive(F, F, 32'h0, F, F, 32'h0);
    bus2.imem_req_ready = 1'b0; bus2.imem_rsp_valid = 1'b0; bus2.imem_rsp_data = 32'h0;
    bus2.instr_ready = 1'b0; bus2.pc_src = 1'b0; bus2.target = 32'h0;

    // ---- directed table: sequential fetch, branch, ignored strays, misalign halt
    tbl[0]  = mk(T, T, 32'hDEAD_0000, T, T, 32'h3,  T, 32'h0,  F, 32'h0, 32'h0, 64'd0, F, 32'h0);
    tbl[1]  = mk(F, T, 32'h0000_0013, F, F, 32'h0,  F, 32'h0,  F, 32'h0, 32'h0, 64'd0, F, 32'h0);
    tbl[2]  = mk(F, F, 32'h0,         T, F, 32'h0,  F, 32'h0,  T, 32'h0000_0013, 32'h0, 64'd0, F, 32'h0);
    tbl[3]  = mk(T, F, 32'h0,         F, F, 32'h0,  T, 32'h4,  F, 32'h0, 32'h0, 64'd1, F, 32'h0);
    tbl[4]  = mk(F, T, 32'h0040_0093, F, F, 32'h0,  F, 32'h0,  F, 32'h0, 32'h0, 64'd1, F, 32'h0);
    tbl[5]  = mk(F, F, 32'h0,         T, F, 32'h0,  F, 32'h0,  T, 32'h0040_0093, 32'h4, 64'd1, F, 32'h0);
    tbl[6]  = mk(T, F, 32'h0,         F, F, 32'h0,  T, 32'h8,  F, 32'h0, 32'h0, 64'd2, F, 32'h0);
    tbl[7]  = mk(F, T, 32'h0080_0113, F, F, 32'h0,  F, 32'h0,  F, 32'h0, 32'h0, 64'd2, F, 32'h0);
    tbl[8]  = mk(F, F, 32'h0,         T, T, 32'h40, F, 32'h0,  T, 32'h0080_0113, 32'h8, 64'd2, F, 32'h0);
    tbl[9]  = mk(T, F, 32'h0,         F, F, 32'h0,  T, 32'h40, F, 32'h0, 32'h0, 64'd3, F, 32'h0);
    tbl[10] = mk(F, T, 32'h00C0_0193, F, F, 32'h0,  F, 32'h0,  F, 32'h0, 32'h0, 64'd3, F, 32'h0);
    tbl[11] = mk(F, F, 32'h0,         T, T, 32'h102, F, 32'h0, T, 32'h00C0_0193, 32'h40, 64'd3, F, 32'h0);
    tbl[12] = mk(T, T, 32'h1111_1111, T, F, 32'h0,  F, 32'h0,  F, 32'h0, 32'h0, 64'd3, T, 32'h102);
    tbl[13] = mk(T, T, 32'h2222_2222, T, T, 32'h80, F, 32'h0,  F, 32'h0, 32'h0, 64'd3, T, 32'h102);

    do_reset("tbl");
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      chk($sformatf("tbl%0d req_valid", i), bus.imem_req_valid, tbl[i].e_rv);
      if (tbl[i].e_rv) chk($sformatf("tbl%0d addr", i), bus.imem_addr, tbl[i].e_addr);
      chk($sformatf("tbl%0d instr_valid", i), bus.instr_valid, tbl[i].e_iv);
      if (tbl[i].e_iv) begin
        chk($sformatf("tbl%0d instr", i), bus.instr, tbl[i].e_instr);
        chk($sformatf("tbl%0d instr_pc", i), bus.instr_pc, tbl[i].e_ipc);
      end
      chk($sformatf("tbl%0d instret", i), bus.instret, tbl[i].e_ret);
      chk($sformatf("tbl%0d misalign", i), bus.misalign_err, tbl[i].e_err);
      if (tbl[i].e_err) chk($sformatf("tbl%0d err_pc", i), bus.err_pc, tbl[i].e_epc);
      drive(tbl[i].rdy, tbl[i].rsp, tbl[i].data, tbl[i].ir, tbl[i].ps, tbl[i].tg);
    end

    // ---- backpressure: request and held instruction stay stable, one request only
    do_reset("bp");
    hs_base = hs;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp req_valid", bus.imem_req_valid, 1);
      chk("bp addr stable", bus.imem_addr, 0);
      drive(F, F, 32'h0, F, F, 32'h0);
    end
    @(negedge clk);
    chk("bp addr accept", bus.imem_addr, 0);
    drive(T, F, 32'h0, F, F, 32'h0);
    @(negedge clk);
    chk("bp wait req_valid", bus.imem_req_valid, 0);
    drive(T, T, 32'h0000_BEEF, F, F, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp hold valid", bus.instr_valid, 1);
      chk("bp hold instr", bus.instr, 32'h0000_BEEF);
      chk("bp hold instr_pc", bus.instr_pc, 0);
      chk("bp hold req_valid", bus.imem_req_valid, 0);
      drive(T, T, 32'h5555_5555, F, T, 32'h200);
    end
    @(negedge clk);
    drive(F, F, 32'h0, T, F, 32'h0);
    @(negedge clk);
    chk("bp one request", hs - hs_base, 1);
    chk("bp next addr", bus.imem_addr, 32'h4);
    chk("bp instret", bus.instret, 1);

    // ---- reset while waiting on a response
    do_reset("rw");
    drive(T, F, 32'h0, F, F, 32'h0);
    @(negedge clk); drive(F, T, 32'hAAAA_0001, F, F, 32'h0);
    @(negedge clk); drive(F, F, 32'h0, T, F, 32'h0);
    @(negedge clk);
    chk("rw pre addr", bus.imem_addr, 32'h4);
    drive(T, F, 32'h0, F, F, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    drive(F, F, 32'h0, F, F, 32'h0);
    #1 check_reset("rw");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rw refetch valid", bus.imem_req_valid, 1);
    chk("rw refetch addr", bus.imem_addr, 0);
    drive(T, F, 32'h0, F, F, 32'h0);
    @(negedge clk); drive(F, T, 32'hAAAA_0002, F, F, 32'h0);
    @(negedge clk);
    chk("rw instr", bus.instr, 32'hAAAA_0002);
    chk("rw instr_pc", bus.instr_pc, 0);

    // ---- PC+4 wrap on the second instance
    @(negedge clk);
    rst2_n = 1'b0;
    @(negedge clk);
    rst2_n = 1'b1;
    #1;
    chk("wrap first addr", bus2.imem_addr, 32'hFFFF_FFFC);
    chk("wrap first valid", bus2.imem_req_valid, 1);
    bus2.imem_req_ready = 1'b1;
    @(negedge clk);
    bus2.imem_req_ready = 1'b0; bus2.imem_rsp_valid = 1'b1; bus2.imem_rsp_data = 32'h0000_0013;
    @(negedge clk);
    chk("wrap instr_pc", bus2.instr_pc, 32'hFFFF_FFFC);
    bus2.imem_rsp_valid = 1'b0; bus2.instr_ready = 1'b1; bus2.pc_src = 1'b0;
    @(negedge clk);
    bus2.instr_ready = 1'b0;
    chk("wrap next addr", bus2.imem_addr, 32'h0);
    chk("wrap next valid", bus2.imem_req_valid, 1);

    // ---- randomized traffic against the model
    do_reset("rnd");
    model_init();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (($urandom % 300) == 0 || halt_cnt > 4) begin
        do_reset("rnd");
        model_init();
        continue;
      end
      exp_rv = !m_halt && !m_pending && !m_have;
      chk("rnd req_valid", bus.imem_req_valid, exp_rv);
      if (exp_rv) chk("rnd addr", bus.imem_addr, m_pc);
      chk("rnd instr_valid", bus.instr_valid, m_have);
      if (m_have) begin
        chk("rnd instr", bus.instr, m_instr);
        chk("rnd instr_pc", bus.instr_pc, m_pc);
      end
      chk("rnd misalign", bus.misalign_err, m_err);
      if (m_err) chk("rnd err_pc", bus.err_pc, m_errpc);
      chk("rnd instret", bus.instret, m_instret);

      rdy  = ($urandom % 3) != 0;
      ir   = ($urandom % 2) != 0;
      ps   = ($urandom % 2) != 0;
      data = $urandom;
      r    = $urandom % 20;
      tg   = ($urandom & 32'hFFFF_FFFC) | ((r == 0) ? ($urandom % 3 + 1) : 0);
      rsp  = 1'b0;

      if (m_have && ir) begin
        m_have = 1'b0;
        if (ps && (tg % 4) != 0) begin
          m_halt = 1'b1; m_err = 1'b1; m_errpc = tg;
        end else begin
          m_pc = ps ? tg : m_pc + 32'd4;
          m_instret = m_instret + 64'd1;
        end
      end
      if (m_pending) begin
        if (m_delay == 0) begin
          rsp = 1'b1; m_have = 1'b1; m_instr = data; m_pending = 1'b0;
        end else m_delay--;
      end else if (($urandom % 4) == 0) rsp = 1'b1;
      if (exp_rv && rdy) begin
        m_pending = 1'b1;
        m_delay = $urandom % 3;
      end
      if (m_halt) halt_cnt++;
      drive(rdy, rsp, data, ir, ps, tg);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
